// File: rtl/axis_tx_mac_model.sv
// TX MAC model: registered-ready AXI-Stream sink with programmable inter-frame gap,
// endian-converting monitor mirror, per-frame statistics and saturating frame counters.
module axis_tx_mac_model #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned IFG_CYCLES      = 2,
  parameter bit          SWAP_ENDIAN     = 1'b1,
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter int unsigned MAX_FRAME_BYTES = 1518,
  localparam int unsigned KEEP_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  coreclk,
  input  logic                  tx_axis_aresetn,
  input  logic [7:0]            tx_ifg_delay,
  input  logic [DATA_WIDTH-1:0] s_axis_tx_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tx_tkeep,
  input  logic                  s_axis_tx_tlast,
  input  logic                  s_axis_tx_tuser,
  input  logic                  s_axis_tx_tvalid,
  output logic                  s_axis_tx_tready,
  output logic [DATA_WIDTH-1:0] m_mon_tdata,
  output logic [KEEP_WIDTH-1:0] m_mon_tkeep,
  output logic                  m_mon_tlast,
  output logic                  m_mon_tvalid,
  output logic                  stat_valid,
  output logic [15:0]           stat_bytes,
  output logic [3:0]            stat_flags,
  output logic [31:0]           frames_ok,
  output logic [31:0]           frames_err
);

  localparam logic [KEEP_WIDTH-1:0] KeepAll = '1;
  localparam logic [KEEP_WIDTH-1:0] KeepOne = {{(KEEP_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StData, StGap} state_e;

  state_e          r_state, w_state_nxt;
  logic [8:0]      r_gap_cnt, w_gap_nxt;
  logic [8:0]      w_gap_len;
  logic            w_accept;
  logic [15:0]     w_beat_bytes;
  logic [16:0]     w_sum;
  logic [15:0]     w_total;
  logic            w_keep_contig;
  logic            w_beat_keep_err;
  logic            w_keep_err;
  logic            w_user_err;
  logic            w_under;
  logic            w_over;
  logic [3:0]      w_flags;
  logic [15:0]     r_acc_bytes;
  logic            r_acc_keep_err;
  logic            r_acc_user;
  logic [DATA_WIDTH-1:0] w_mon_data;
  logic [KEEP_WIDTH-1:0] w_mon_keep;

  assign s_axis_tx_tready = (r_state != StGap);
  assign w_accept         = s_axis_tx_tvalid && s_axis_tx_tready;
  assign w_gap_len        = 9'(IFG_CYCLES) + {1'b0, tx_ifg_delay};

  // Byte count of the current beat (popcount of tkeep).
  always_comb begin
    w_beat_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      w_beat_bytes = w_beat_bytes + {15'd0, s_axis_tx_tkeep[i]};
    end
  end

  // Running totals including the current beat; this is what a tlast beat reports.
  always_comb begin
    w_sum           = {1'b0, r_acc_bytes} + {1'b0, w_beat_bytes};
    w_total         = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    // Contiguous-from-LSB masks have no set bit above a clear bit.
    w_keep_contig   = ((s_axis_tx_tkeep & (s_axis_tx_tkeep + KeepOne)) == '0);
    w_beat_keep_err = s_axis_tx_tlast ? ((s_axis_tx_tkeep == '0) || !w_keep_contig)
                                      : (s_axis_tx_tkeep != KeepAll);
    w_keep_err      = r_acc_keep_err | w_beat_keep_err;
    w_user_err      = r_acc_user | s_axis_tx_tuser;
    w_under         = ({16'd0, w_total} < MIN_FRAME_BYTES);
    w_over          = ({16'd0, w_total} > MAX_FRAME_BYTES);
    w_flags         = {w_keep_err, w_over, w_under, w_user_err};
  end

  // Monitor conversion: byte-reverse data and bit-reverse keep when enabled.
  always_comb begin
    w_mon_data = s_axis_tx_tdata;
    w_mon_keep = s_axis_tx_tkeep;
    if (SWAP_ENDIAN) begin
      for (int i = 0; i < KEEP_WIDTH; i++) begin
        w_mon_data[8*(KEEP_WIDTH-1-i) +: 8] = s_axis_tx_tdata[8*i +: 8];
        w_mon_keep[KEEP_WIDTH-1-i]          = s_axis_tx_tkeep[i];
      end
    end
  end

  // Next-state logic; the gap counter is loaded with N-1 so GAP lasts exactly N cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    unique case (r_state)
      StIdle, StData: begin
        if (w_accept) begin
          if (s_axis_tx_tlast) begin
            if (w_gap_len != 9'd0) begin
              w_state_nxt = StGap;
              w_gap_nxt   = w_gap_len - 9'd1;
            end else begin
              w_state_nxt = StIdle;
            end
          end else begin
            w_state_nxt = StData;
          end
        end
      end
      StGap: begin
        if (r_gap_cnt == 9'd0) begin
          w_state_nxt = StIdle;
        end else begin
          w_gap_nxt = r_gap_cnt - 9'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and gap counter registers.
  always_ff @(posedge coreclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      r_state   <= StIdle;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Frame accumulators, statistics record and saturating counters.
  always_ff @(posedge coreclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      r_acc_bytes    <= '0;
      r_acc_keep_err <= 1'b0;
      r_acc_user     <= 1'b0;
      stat_valid     <= 1'b0;
      stat_bytes     <= '0;
      stat_flags     <= '0;
      frames_ok      <= '0;
      frames_err     <= '0;
    end else begin
      stat_valid <= 1'b0;
      if (w_accept) begin
        if (s_axis_tx_tlast) begin
          stat_valid     <= 1'b1;
          stat_bytes     <= w_total;
          stat_flags     <= w_flags;
          r_acc_bytes    <= '0;
          r_acc_keep_err <= 1'b0;
          r_acc_user     <= 1'b0;
          if (w_flags == 4'd0) begin
            if (frames_ok != 32'hFFFF_FFFF) frames_ok <= frames_ok + 32'd1;
          end else begin
            if (frames_err != 32'hFFFF_FFFF) frames_err <= frames_err + 32'd1;
          end
        end else begin
          r_acc_bytes    <= w_total;
          r_acc_keep_err <= w_keep_err;
          r_acc_user     <= w_user_err;
        end
      end
    end
  end

  // Monitor stream register; data/keep/last hold when no beat is accepted.
  always_ff @(posedge coreclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      m_mon_tvalid <= 1'b0;
      m_mon_tdata  <= '0;
      m_mon_tkeep  <= '0;
      m_mon_tlast  <= 1'b0;
    end else begin
      m_mon_tvalid <= w_accept;
      if (w_accept) begin
        m_mon_tdata <= w_mon_data;
        m_mon_tkeep <= w_mon_keep;
        m_mon_tlast <= s_axis_tx_tlast;
      end
    end
  end

endmodule
